round_referee: RTL and testbench



---
 rtl/round_referee.sv | 166 ++++++++++++++++
 tb/tb_round_referee.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// Round controller for a two-player card game: collects one card per player per round,
// presents both cards to an external comparator, scores the result and declares a winner.
module round_referee #(
  parameter int unsigned WIN_SCORE  = 3,
  parameter int unsigned MAX_ROUNDS = 9
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] p1_card_i,
  input  logic       p1_valid_i,
  output logic       p1_ready_o,
  input  logic [3:0] p2_card_i,
  input  logic       p2_valid_i,
  output logic       p2_ready_o,
  output logic [3:0] p1_handcard_o,
  output logic [3:0] p2_handcard_o,
  input  logic [1:0] matchresult_i,
  output logic [1:0] round_result_o,
  output logic       result_valid_o,
  output logic [3:0] p1_score_o,
  output logic [3:0] p2_score_o,
  output logic [3:0] round_cnt_o,
  output logic       game_over_o,
  output logic [1:0] winner_o,
  output logic       protocol_err_o
);

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [3:0] MaxRounds = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       p1_held_q, p1_held_d;
  logic       p2_held_q, p2_held_d;
  logic [3:0] p1_hand_q, p1_hand_d;
  logic [3:0] p2_hand_q, p2_hand_d;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic [1:0] round_result_q, round_result_d;
  logic       result_valid_q, result_valid_d;
  logic [1:0] winner_q, winner_d;
  logic       protocol_err_q, protocol_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      p1_held_q      <= 1'b0;
      p2_held_q      <= 1'b0;
      p1_hand_q      <= 4'd0;
      p2_hand_q      <= 4'd0;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      round_cnt_q    <= 4'd0;
      round_result_q <= 2'b00;
      result_valid_q <= 1'b0;
      winner_q       <= 2'b00;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      p1_held_q      <= p1_held_d;
      p2_held_q      <= p2_held_d;
      p1_hand_q      <= p1_hand_d;
      p2_hand_q      <= p2_hand_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      round_cnt_q    <= round_cnt_d;
      round_result_q <= round_result_d;
      result_valid_q <= result_valid_d;
      winner_q       <= winner_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    p1_held_d      = p1_held_q;
    p2_held_d      = p2_held_q;
    p1_hand_d      = p1_hand_q;
    p2_hand_d      = p2_hand_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    round_cnt_d    = round_cnt_q;
    round_result_d = round_result_q;
    result_valid_d = 1'b0;
    winner_d       = winner_q;
    protocol_err_d = protocol_err_q;

    unique case (state_q)
      IDLE, DONE: begin
        // Handcards are deliberately kept so the last round stays visible until new cards arrive.
        if (start_i) begin
          p1_score_d     = 4'd0;
          p2_score_d     = 4'd0;
          round_cnt_d    = 4'd0;
          protocol_err_d = 1'b0;
          winner_d       = 2'b00;
          p1_held_d      = 1'b0;
          p2_held_d      = 1'b0;
          state_d        = COLLECT;
        end
      end
      COLLECT: begin
        if (p1_valid_i && !p1_held_q) begin
          p1_hand_d = p1_card_i;
          p1_held_d = 1'b1;
        end
        if (p2_valid_i && !p2_held_q) begin
          p2_hand_d = p2_card_i;
          p2_held_d = 1'b1;
        end
        if (p1_held_d && p2_held_d) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        case (matchresult_i)
          2'b10:   p1_score_d = p1_score_q + 4'd1;
          2'b11:   p2_score_d = p2_score_q + 4'd1;
          2'b01:   ;
          default: protocol_err_d = 1'b1;
        endcase
        round_cnt_d    = round_cnt_q + 4'd1;
        round_result_d = matchresult_i;
        result_valid_d = 1'b1;
        p1_held_d      = 1'b0;
        p2_held_d      = 1'b0;
        // Winner is resolved here so it appears together with game_over on DONE entry.
        if (p1_score_d == WinScore || p2_score_d == WinScore || round_cnt_d == MaxRounds) begin
          state_d = DONE;
          if (p1_score_d > p2_score_d) begin
            winner_d = 2'b10;
          end else if (p2_score_d > p1_score_d) begin
            winner_d = 2'b11;
          end else begin
            winner_d = 2'b01;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign p1_ready_o     = (state_q == COLLECT) && !p1_held_q;
  assign p2_ready_o     = (state_q == COLLECT) && !p2_held_q;
  assign p1_handcard_o  = p1_hand_q;
  assign p2_handcard_o  = p2_hand_q;
  assign round_result_o = round_result_q;
  assign result_valid_o = result_valid_q;
  assign p1_score_o     = p1_score_q;
  assign p2_score_o     = p2_score_q;
  assign round_cnt_o    = round_cnt_q;
  assign game_over_o    = (state_q == DONE);
  assign winner_o       = winner_q;
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee: a default instance plus a MAX_ROUNDS=2 instance share stimulus,
// each driven by its own behavioural comparator on its handcards.
module tb_round_referee;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [3:0] p1Card, p2Card;
  logic       p1Valid, p2Valid;
  logic       overrideEn;
  logic [1:0] overrideVal;

  logic       aP1Ready, aP2Ready, aResultValid, aGameOver, aProtocolErr;
  logic [3:0] aP1Hand, aP2Hand, aP1Score, aP2Score, aRoundCnt;
  logic [1:0] aMatch, aRoundResult, aWinner;

  logic       bP1Ready, bP2Ready, bResultValid, bGameOver, bProtocolErr;
  logic [3:0] bP1Hand, bP2Hand, bP1Score, bP2Score, bRoundCnt;
  logic [1:0] bMatch, bRoundResult, bWinner;

  int checkCount = 0;
  int errorCount = 0;

  function automatic logic [1:0] compareCards(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 2'b10;
    if (b > a) return 2'b11;
    return 2'b01;
  endfunction

  assign aMatch = overrideEn ? overrideVal : compareCards(aP1Hand, aP2Hand);
  assign bMatch = overrideEn ? overrideVal : compareCards(bP1Hand, bP2Hand);

  round_referee dutA (
    .clk_i(clk), .rst_ni(rstN), .start_i(start),
    .p1_card_i(p1Card), .p1_valid_i(p1Valid), .p1_ready_o(aP1Ready),
    .p2_card_i(p2Card), .p2_valid_i(p2Valid), .p2_ready_o(aP2Ready),
    .p1_handcard_o(aP1Hand), .p2_handcard_o(aP2Hand), .matchresult_i(aMatch),
    .round_result_o(aRoundResult), .result_valid_o(aResultValid),
    .p1_score_o(aP1Score), .p2_score_o(aP2Score), .round_cnt_o(aRoundCnt),
    .game_over_o(aGameOver), .winner_o(aWinner), .protocol_err_o(aProtocolErr)
  );

  round_referee #(.WIN_SCORE(3), .MAX_ROUNDS(2)) dutB (
    .clk_i(clk), .rst_ni(rstN), .start_i(start),
    .p1_card_i(p1Card), .p1_valid_i(p1Valid), .p1_ready_o(bP1Ready),
    .p2_card_i(p2Card), .p2_valid_i(p2Valid), .p2_ready_o(bP2Ready),
    .p1_handcard_o(bP1Hand), .p2_handcard_o(bP2Hand), .matchresult_i(bMatch),
    .round_result_o(bRoundResult), .result_valid_o(bResultValid),
    .p1_score_o(bP1Score), .p2_score_o(bP2Score), .round_cnt_o(bRoundCnt),
    .game_over_o(bGameOver), .winner_o(bWinner), .protocol_err_o(bProtocolErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one cycle of inputs starting at a negedge; returns at the next negedge with inputs idle.
  task automatic applyStimulus(input logic s, input logic v1, input logic [3:0] c1,
                               input logic v2, input logic [3:0] c2);
    start = s; p1Valid = v1; p1Card = c1; p2Valid = v2; p2Card = c2;
    @(negedge clk);
    start = 1'b0; p1Valid = 1'b0; p2Valid = 1'b0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // Full round: cards accepted, EVAL, then returns in the cycle where results are visible.
  task automatic playRound(input logic [3:0] c1, input logic [3:0] c2);
    applyStimulus(1'b0, 1'b1, c1, 1'b1, c2);
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, {6'd0, aP1Ready, aP2Ready}, 8'h00);
    checkOutput({tag, "_hand"}, {aP1Hand, aP2Hand}, 8'h00);
    checkOutput({tag, "_score"}, {aP1Score, aP2Score}, 8'h00);
    checkOutput({tag, "_cnt"}, {4'd0, aRoundCnt}, 8'h00);
    checkOutput({tag, "_flags"}, {2'd0, aRoundResult, aWinner, aResultValid, aProtocolErr}, 8'h00);
    checkOutput({tag, "_over"}, {7'd0, aGameOver}, 8'h00);
  endtask

  initial begin
    start = 0; p1Card = 0; p2Card = 0; p1Valid = 0; p2Valid = 0;
    overrideEn = 0; overrideVal = 2'b00; rstN = 1'b0;

    doReset();
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b1, 4'd6, 1'b1, 4'd2);
    checkOutput("idle_ignore_hand", {aP1Hand, aP2Hand}, 8'h00);

    $display("[TB] basic win");
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("basic_ready", {6'd0, aP1Ready, aP2Ready}, 8'h03);
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b1, 4'd4);
    checkOutput("basic_eval_ready", {6'd0, aP1Ready, aP2Ready}, 8'h00);
    checkOutput("basic_hand", {aP1Hand, aP2Hand}, 8'h94);
    checkOutput("basic_eval_rv", {7'd0, aResultValid}, 8'h00);
    tick();
    checkOutput("basic_rv", {7'd0, aResultValid}, 8'h01);
    checkOutput("basic_rr", {6'd0, aRoundResult}, 8'h02);
    checkOutput("basic_score", {aP1Score, aP2Score}, 8'h10);
    checkOutput("basic_cnt", {4'd0, aRoundCnt}, 8'h01);
    checkOutput("basic_collect", {5'd0, aGameOver, aP1Ready, aP2Ready}, 8'h03);
    tick();
    checkOutput("basic_rv_pulse", {7'd0, aResultValid}, 8'h00);

    $display("[TB] staggered cards");
    doReset();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 4'd0);
    checkOutput("stag_ready", {6'd0, aP1Ready, aP2Ready}, 8'h01);
    checkOutput("stag_hand1", {4'd0, aP1Hand}, 8'h05);
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 4'd0);
    checkOutput("stag_dup_hand1", {4'd0, aP1Hand}, 8'h05);
    checkOutput("stag_dup_ready", {6'd0, aP1Ready, aP2Ready}, 8'h01);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    checkOutput("stag_hand", {aP1Hand, aP2Hand}, 8'h55);
    tick();
    checkOutput("stag_rr", {5'd0, aResultValid, aRoundResult}, 8'h05);
    checkOutput("stag_score", {aP1Score, aP2Score}, 8'h00);
    checkOutput("stag_cnt", {4'd0, aRoundCnt}, 8'h01);

    $display("[TB] win score end");
    doReset();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    playRound(4'd2, 4'd8);
    playRound(4'd2, 4'd8);
    checkOutput("win_mid_over", {7'd0, aGameOver}, 8'h00);
    playRound(4'd2, 4'd8);
    checkOutput("win_over", {5'd0, aGameOver, aWinner}, 8'h07);
    checkOutput("win_score", {aP1Score, aP2Score}, 8'h03);
    checkOutput("win_cnt", {4'd0, aRoundCnt}, 8'h03);
    applyStimulus(1'b0, 1'b1, 4'd12, 1'b1, 4'd13);
    checkOutput("win_ignore_hand", {aP1Hand, aP2Hand}, 8'h28);
    checkOutput("win_ignore_ready", {6'd0, aP1Ready, aP2Ready}, 8'h00);
    tick();
    checkOutput("win_hold", {5'd0, aGameOver, aResultValid, aRoundCnt[0]}, 8'h05);

    $display("[TB] max rounds tie");
    doReset();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    playRound(4'd9, 4'd3);
    checkOutput("tie_mid_over", {7'd0, bGameOver}, 8'h00);
    playRound(4'd1, 4'd6);
    checkOutput("tie_over", {5'd0, bGameOver, bWinner}, 8'h05);
    checkOutput("tie_cnt", {4'd0, bRoundCnt}, 8'h02);
    checkOutput("tie_score", {bP1Score, bP2Score}, 8'h11);
    checkOutput("tie_default_running", {5'd0, aGameOver, aWinner}, 8'h00);

    $display("[TB] illegal result");
    doReset();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    overrideEn = 1'b1; overrideVal = 2'b00;
    playRound(4'd4, 4'd4);
    overrideEn = 1'b0;
    checkOutput("ill_err", {7'd0, aProtocolErr}, 8'h01);
    checkOutput("ill_rr", {5'd0, aResultValid, aRoundResult}, 8'h04);
    checkOutput("ill_score", {aP1Score, aP2Score}, 8'h00);
    checkOutput("ill_cnt", {4'd0, aRoundCnt}, 8'h01);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("ill_start_ignored", {3'd0, aProtocolErr, aRoundCnt}, 8'h11);
    playRound(4'd8, 4'd1);
    playRound(4'd8, 4'd1);
    playRound(4'd8, 4'd1);
    checkOutput("ill_done", {4'd0, aProtocolErr, aGameOver, aWinner}, 8'h0E);
    checkOutput("ill_done_cnt", {4'd0, aRoundCnt}, 8'h04);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("ill_restart", {4'd0, aProtocolErr, aGameOver, aWinner}, 8'h00);
    checkOutput("ill_restart_cnt", {aP1Score, aRoundCnt}, 8'h00);
    checkOutput("ill_restart_ready", {6'd0, aP1Ready, aP2Ready}, 8'h03);

    $display("[TB] reset mid operation");
    doReset();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    playRound(4'd7, 4'd3);
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b1, 4'd3);
    rstN = 1'b0;
    #1;
    checkAllZero("rst_mid");
    tick();
    checkOutput("rst_no_rv", {7'd0, aResultValid}, 8'h00);
    rstN = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("rst_fresh", {5'd0, aGameOver, aP1Ready, aP2Ready}, 8'h03);
    playRound(4'd7, 4'd3);
    checkOutput("rst_fresh_score", {aP1Score, aRoundCnt}, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
